// File: rtl/tmds_encoder.sv
// DVI TMDS 8b/10b encoder for one channel: three register stages, running-disparity
// DC balancing in the last stage, optional output inversion for board P/N swap.
module tmds_encoder #(
    parameter logic INVERT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       de,
    input  logic [7:0] d,
    input  logic [1:0] c,
    output logic [9:0] dout,
    output logic [4:0] disparity
);

    localparam logic [9:0] CTRL_00  = 10'h354;
    localparam logic [9:0] CTRL_01  = 10'h0AB;
    localparam logic [9:0] CTRL_10  = 10'h154;
    localparam logic [9:0] CTRL_11  = 10'h2AB;
    localparam logic [9:0] INV_MASK = {10{INVERT}};

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    // Stage 1: capture inputs and count ones of the pixel byte.
    logic       s1_de;
    logic [1:0] s1_c;
    logic [7:0] s1_d;
    logic [3:0] s1_n1;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_de <= 1'b0;
            s1_c  <= 2'b00;
            s1_d  <= 8'h00;
            s1_n1 <= 4'd0;
        end else begin
            s1_de <= de;
            s1_c  <= c;
            s1_d  <= d;
            s1_n1 <= ones8(d);
        end
    end

    // Stage 2: transition-minimising q_m.
    logic       use_xnor;
    logic [8:0] qm;

    always_comb begin
        use_xnor = (s1_n1 > 4'd4) || ((s1_n1 == 4'd4) && !s1_d[0]);
        qm       = 9'd0;
        qm[0]    = s1_d[0];
        for (int i = 1; i < 8; i++) begin
            qm[i] = use_xnor ? ~(qm[i-1] ^ s1_d[i]) : (qm[i-1] ^ s1_d[i]);
        end
        qm[8] = ~use_xnor;
    end

    logic       s2_de;
    logic [1:0] s2_c;
    logic [8:0] s2_qm;
    logic [3:0] s2_n1q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_de  <= 1'b0;
            s2_c   <= 2'b00;
            s2_qm  <= 9'd0;
            s2_n1q <= 4'd0;
        end else begin
            s2_de  <= s1_de;
            s2_c   <= s1_c;
            s2_qm  <= qm;
            s2_n1q <= ones8(qm[7:0]);
        end
    end

    // Stage 3: DC balancing. diff is N1q-N0q; everything runs in 6-bit signed.
    logic [4:0]        cnt;
    logic signed [5:0] cnt_w;
    logic signed [5:0] diff;
    logic signed [5:0] two_q8;
    logic signed [5:0] two_nq8;
    logic [4:0]        cnt_nxt;
    logic [9:0]        sym;

    always_comb begin
        cnt_w   = $signed({cnt[4], cnt});
        diff    = $signed({1'b0, s2_n1q, 1'b0}) - 6'sd8;
        two_q8  = $signed({4'd0, s2_qm[8], 1'b0});
        two_nq8 = $signed({4'd0, ~s2_qm[8], 1'b0});
        sym     = CTRL_00;
        cnt_nxt = 5'd0;
        if (!s2_de) begin
            case (s2_c)
                2'b00:   sym = CTRL_00;
                2'b01:   sym = CTRL_01;
                2'b10:   sym = CTRL_10;
                default: sym = CTRL_11;
            endcase
            cnt_nxt = 5'd0;
        end else if ((cnt_w == 6'sd0) || (diff == 6'sd0)) begin
            sym     = {~s2_qm[8], s2_qm[8], s2_qm[8] ? s2_qm[7:0] : ~s2_qm[7:0]};
            cnt_nxt = s2_qm[8] ? 5'(cnt_w + diff) : 5'(cnt_w - diff);
        end else if (((cnt_w > 6'sd0) && (diff > 6'sd0)) ||
                     ((cnt_w < 6'sd0) && (diff < 6'sd0))) begin
            sym     = {1'b1, s2_qm[8], ~s2_qm[7:0]};
            cnt_nxt = 5'(cnt_w + two_q8 - diff);
        end else begin
            sym     = {1'b0, s2_qm[8], s2_qm[7:0]};
            cnt_nxt = 5'(cnt_w - two_nq8 + diff);
        end
    end

    // Inversion is applied to the line symbol only; cnt always tracks the true symbol.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= CTRL_00 ^ INV_MASK;
            cnt  <= 5'd0;
        end else begin
            dout <= sym ^ INV_MASK;
            cnt  <= cnt_nxt;
        end
    end

    assign disparity = cnt;

endmodule

// File: tb/tb_tmds_encoder.sv
// Self-checking bench for tmds_encoder: normal and inverted instances driven in
// parallel, compared against an arithmetic DVI encoder model with 3-cycle latency.
module tb_tmds_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       de  = 1'b0;
    logic [7:0] d   = 8'h00;
    logic [1:0] c   = 2'b00;
    logic [9:0] dout, dout_i;
    logic [4:0] disparity, disparity_i;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tmds_encoder #(.INVERT(1'b0)) dut (
        .clk(clk), .rst(rst), .de(de), .d(d), .c(c),
        .dout(dout), .disparity(disparity)
    );

    tmds_encoder #(.INVERT(1'b1)) dut_inv (
        .clk(clk), .rst(rst), .de(de), .d(d), .c(c),
        .dout(dout_i), .disparity(disparity_i)
    );

    typedef struct {
        logic [9:0] sym;
        int         disp;
        logic       de;
        logic [7:0] d;
    } exp_t;

    exp_t pipe[$];
    exp_t cur;
    exp_t rst_entry;
    int   m_cnt = 0;

    // Reference encoder: q_m bits from prefix parity of d, disparity as plain integers.
    task automatic model_push(input logic de_v, input logic [7:0] d_v, input logic [1:0] c_v);
        exp_t       e;
        int         n1, n1q, n0q, par;
        logic       xnor_sel;
        logic [8:0] q;
        e.de = de_v;
        e.d  = d_v;
        if (!de_v) begin
            case (c_v)
                2'b00:   e.sym = 10'h354;
                2'b01:   e.sym = 10'h0AB;
                2'b10:   e.sym = 10'h154;
                default: e.sym = 10'h2AB;
            endcase
            m_cnt = 0;
        end else begin
            n1 = 0;
            for (int i = 0; i < 8; i++) n1 += int'(d_v[i]);
            xnor_sel = (n1 > 4) || (n1 == 4 && d_v[0] == 1'b0);
            par = 0;
            for (int i = 0; i < 8; i++) begin
                par  = par ^ int'(d_v[i]);
                q[i] = xnor_sel ? 1'((par ^ (i % 2)) & 1) : 1'(par & 1);
            end
            q[8] = !xnor_sel;
            n1q = 0;
            for (int i = 0; i < 8; i++) n1q += int'(q[i]);
            n0q = 8 - n1q;
            if (m_cnt == 0 || n1q == n0q) begin
                if (q[8]) begin
                    e.sym = {2'b01, q[7:0]};
                    m_cnt = m_cnt + n1q - n0q;
                end else begin
                    e.sym = {2'b10, ~q[7:0]};
                    m_cnt = m_cnt + n0q - n1q;
                end
            end else if ((m_cnt > 0 && n1q > n0q) || (m_cnt < 0 && n0q > n1q)) begin
                e.sym = {1'b1, q[8], ~q[7:0]};
                m_cnt = m_cnt + 2 * int'(q[8]) + n0q - n1q;
            end else begin
                e.sym = {1'b0, q[8], q[7:0]};
                m_cnt = m_cnt - 2 * (1 - int'(q[8])) + n1q - n0q;
            end
        end
        e.disp = m_cnt;
        pipe.push_back(e);
    endtask

    // One clock: drive inputs at negedge, leave cur = expected output after the next posedge.
    task automatic step(input logic r, input logic dv, input logic [7:0] dd, input logic [1:0] cc);
        @(negedge clk);
        rst = r;
        de  = dv;
        d   = dd;
        c   = cc;
        if (r) begin
            m_cnt = 0;
            pipe.delete();
            pipe.push_back(rst_entry);
            pipe.push_back(rst_entry);
            cur = rst_entry;
        end else begin
            model_push(dv, dd, cc);
            cur = pipe.pop_front();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 2'($urandom));
            checks += 4;
            if (dout !== 10'h354) begin
                errors++; $display("FAIL reset_dout: got %h expected 354", dout);
            end
            if (disparity !== 5'd0) begin
                errors++; $display("FAIL reset_disp: got %0d expected 0", $signed(disparity));
            end
            if (dout_i !== 10'h0AB) begin
                errors++; $display("FAIL reset_dout_inv: got %h expected 0ab", dout_i);
            end
            if (disparity_i !== 5'd0) begin
                errors++; $display("FAIL reset_disp_inv: got %0d expected 0", $signed(disparity_i));
            end
        end
    endtask

    task automatic test_control();
        logic [9:0] want [6];
        want = '{10'h354, 10'h354, 10'h354, 10'h0AB, 10'h154, 10'h2AB};
        step(1'b1, 1'b0, 8'h00, 2'b00);
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b0, 8'($urandom), (k < 4) ? 2'(k) : 2'b00);
            checks += 4;
            if (dout !== want[k] || dout !== cur.sym) begin
                errors++; $display("FAIL ctrl_dout[%0d]: got %h expected %h", k, dout, want[k]);
            end
            if (disparity !== 5'd0) begin
                errors++; $display("FAIL ctrl_disp[%0d]: got %0d expected 0", k, $signed(disparity));
            end
            if (dout_i !== ~want[k]) begin
                errors++; $display("FAIL ctrl_dout_inv[%0d]: got %h expected %h", k, dout_i, ~want[k]);
            end
            if (disparity_i !== 5'd0) begin
                errors++; $display("FAIL ctrl_disp_inv[%0d]: got %0d expected 0", k, $signed(disparity_i));
            end
        end
    endtask

    task automatic test_zeros();
        logic [9:0] want_sym [4];
        int         want_disp [4];
        want_sym  = '{10'h100, 10'h3FF, 10'h100, 10'h354};
        want_disp = '{-8, 2, -6, 0};
        for (int k = 0; k < 6; k++) begin
            step(1'b0, (k < 3), 8'h00, 2'b00);
            checks += 4;
            if (dout !== cur.sym || disparity !== 5'(cur.disp)) begin
                errors++; $display("FAIL zeros_model[%0d]: got %h/%0d expected %h/%0d",
                                   k, dout, $signed(disparity), cur.sym, cur.disp);
            end
            if (dout_i !== ~cur.sym || disparity_i !== 5'(cur.disp)) begin
                errors++; $display("FAIL zeros_inv[%0d]: got %h/%0d expected %h/%0d",
                                   k, dout_i, $signed(disparity_i), ~cur.sym, cur.disp);
            end
            if (k >= 2) begin
                if (dout !== want_sym[k-2]) begin
                    errors++; $display("FAIL zeros_dout[%0d]: got %h expected %h", k, dout, want_sym[k-2]);
                end
                if (disparity !== 5'(want_disp[k-2])) begin
                    errors++; $display("FAIL zeros_disp[%0d]: got %0d expected %0d",
                                       k, $signed(disparity), want_disp[k-2]);
                end
            end else begin
                checks -= 2;
            end
        end
    endtask

    task automatic test_ones();
        step(1'b0, 1'b0, 8'h00, 2'b00);
        step(1'b0, 1'b1, 8'hFF, 2'b00);
        step(1'b0, 1'b0, 8'h00, 2'b00);
        step(1'b0, 1'b0, 8'h00, 2'b00);
        checks += 4;
        if (dout !== 10'h200) begin
            errors++; $display("FAIL ones_dout: got %h expected 200", dout);
        end
        if (disparity !== 5'(-8)) begin
            errors++; $display("FAIL ones_disp: got %0d expected -8", $signed(disparity));
        end
        if (dout_i !== 10'h1FF) begin
            errors++; $display("FAIL ones_dout_inv: got %h expected 1ff", dout_i);
        end
        if (dout !== cur.sym) begin
            errors++; $display("FAIL ones_model: got %h expected %h", dout, cur.sym);
        end
    endtask

    task automatic test_midreset();
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b1, 8'($urandom), 2'($urandom));
            checks++;
            if (dout !== cur.sym || disparity !== 5'(cur.disp)) begin
                errors++; $display("FAIL mid_pre[%0d]: got %h/%0d expected %h/%0d",
                                   k, dout, $signed(disparity), cur.sym, cur.disp);
            end
        end
        step(1'b1, 1'b1, 8'($urandom), 2'($urandom));
        checks += 2;
        if (dout !== 10'h354 || disparity !== 5'd0) begin
            errors++; $display("FAIL mid_rst: got %h/%0d expected 354/0", dout, $signed(disparity));
        end
        if (dout_i !== 10'h0AB || disparity_i !== 5'd0) begin
            errors++; $display("FAIL mid_rst_inv: got %h/%0d expected 0ab/0", dout_i, $signed(disparity_i));
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 8'($urandom), 2'($urandom));
            checks++;
            if (k < 2) begin
                if (dout !== 10'h354 || disparity !== 5'd0) begin
                    errors++; $display("FAIL mid_flush[%0d]: got %h/%0d expected 354/0",
                                       k, dout, $signed(disparity));
                end
            end else if (dout !== cur.sym || disparity !== 5'(cur.disp)) begin
                errors++; $display("FAIL mid_first: got %h/%0d expected %h/%0d",
                                   dout, $signed(disparity), cur.sym, cur.disp);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] q, dec;
        for (int k = 0; k < 3000; k++) begin
            step(1'b0, ($urandom_range(0, 7) != 0), 8'($urandom), 2'($urandom));
            checks += 5;
            if (dout !== cur.sym) begin
                errors++; $display("FAIL rand_dout[%0d]: got %h expected %h", k, dout, cur.sym);
            end
            if (disparity !== 5'(cur.disp)) begin
                errors++; $display("FAIL rand_disp[%0d]: got %0d expected %0d", k, $signed(disparity), cur.disp);
            end
            if (dout_i !== ~cur.sym) begin
                errors++; $display("FAIL rand_dout_inv[%0d]: got %h expected %h", k, dout_i, ~cur.sym);
            end
            if (disparity_i !== 5'(cur.disp)) begin
                errors++; $display("FAIL rand_disp_inv[%0d]: got %0d expected %0d", k, $signed(disparity_i), cur.disp);
            end
            if ($signed(disparity) > 5'sd10 || $signed(disparity) < -5'sd10) begin
                errors++; $display("FAIL rand_range[%0d]: got %0d expected within +-10", k, $signed(disparity));
            end
            if (cur.de) begin
                q      = dout[9] ? ~dout[7:0] : dout[7:0];
                dec[0] = q[0];
                for (int i = 1; i < 8; i++) dec[i] = dout[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
                checks++;
                if (dec !== cur.d) begin
                    errors++; $display("FAIL rand_decode[%0d]: got %h expected %h", k, dec, cur.d);
                end
            end
        end
    endtask

    initial begin
        rst_entry.sym  = 10'h354;
        rst_entry.disp = 0;
        rst_entry.de   = 1'b0;
        rst_entry.d    = 8'h00;
        test_reset();
        test_control();
        test_zeros();
        test_ones();
        test_midreset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
